// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b - bin, one bit per cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-subtractor cell operating on the current LSBs.
  logic x, y, diff, br_nxt;
  assign x      = sa_q[0];
  assign y      = sb_q[0];
  assign diff   = x ^ y ^ br_q;
  assign br_nxt = (~x & y) | (~(x ^ y) & br_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = {diff, sr_q[WIDTH-1:1]};
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish result; br_q here is the borrow into the MSB.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          d_d     = {diff, sr_q[WIDTH-1:1]};
          bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = br_q ^ br_nxt;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): directed vectors, handshake timing,
// ignored starts and mid-operation reset.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) chk("busy_and_done", 32'(1), 32'(0));
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("d", 32'(d), 32'(e.d));
          chk("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 20 && (busy || done); i++) @(negedge clk);
    if (busy || done) chk("idle_timeout", 32'(1), 32'(0));
  endtask

  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    wait_idle();
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input bit glitch);
    exp_t e;
    e = '{d: ed, bout: eb, ovf: eo};
    sb_q.push_back(e);
    accept(ta, tb_v, tbin);
    for (int k = 1; k <= int'(W) + 1; k++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= int'(W)));
      chk($sformatf("done_c%0d", k), 32'(done), 32'(k == int'(W) + 1));
      if (glitch && (k == 2 || k == int'(W) + 1)) begin
        start = 1'b1;
        a     = 4'h1;
        b     = 4'h1;
        bin   = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 32'(0));
    chk("done_after_done", 32'(done), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_d", 32'(d), 32'(0));
    chk("rst_bout", 32'(bout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0);
    run_op(4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0);
    run_op(4'h5, 4'h3, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    run_op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    run_op(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    // Starts during SHIFT and DONE must be ignored.
    run_op(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1, 1'b1);

    // Abort mid-operation: outputs clear at once, no done follows.
    accept(4'h7, 4'h2, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_d", 32'(d), 32'(0));
    chk("abort_bout", 32'(bout), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(W) + 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
    end
    run_op(4'h7, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);

    run_op(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0);
    run_op(4'h7, 4'h1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
